// File: rtl/sprite_draw_engine_if.sv
// ---------------------------------------------------------------------------
// sprite_draw_engine_if
// Display command interface between the CPU (master) and the sprite draw
// engine (slave).
//   gpu_clear / gpu_draw : level-sampled requests, accepted only while idle
//   vx, vy               : sprite origin (reduced modulo the screen size)
//   n_bits               : sprite height in rows (0..15)
//   sprite_data          : sprite bytes, row 0 in the most significant byte
//   busy                 : command in progress, requests are ignored
//   done                 : one-cycle completion pulse
//   vf                   : collision result of the last completed draw
// ---------------------------------------------------------------------------
interface sprite_draw_engine_if #(
   parameter int MAX_ROWS = 15
);
   logic                  gpu_clear;
   logic                  gpu_draw;
   logic [7:0]            vx;
   logic [7:0]            vy;
   logic [3:0]            n_bits;
   logic [8*MAX_ROWS-1:0] sprite_data;
   logic                  busy;
   logic                  done;
   logic [7:0]            vf;

   modport master (
      output gpu_clear, gpu_draw, vx, vy, n_bits, sprite_data,
      input  busy, done, vf
   );

   modport slave (
      input  gpu_clear, gpu_draw, vx, vy, n_bits, sprite_data,
      output busy, done, vf
   );
endinterface

// File: rtl/sprite_draw_engine.sv
// ---------------------------------------------------------------------------
// sprite_draw_engine
// XOR-draws sprites into a W x H 1-bpp framebuffer held in registers and
// reports pixel collisions. One framebuffer row is read-modify-written per
// cycle; a clear wipes one row per cycle.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   cmd        : command interface (slave side), see sprite_draw_engine_if
//   pix_x/y    : scan-out read address
//   pix_out    : framebuffer bit at (pix_x, pix_y), combinational
// ---------------------------------------------------------------------------
module sprite_draw_engine #(
   parameter int W        = 64,
   parameter int H        = 32,
   parameter int MAX_ROWS = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sprite_draw_engine_if.slave  cmd,
   input  logic [$clog2(W)-1:0] pix_x,
   input  logic [$clog2(H)-1:0] pix_y,
   output logic                 pix_out
);

   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);
   localparam int SW = 8 * MAX_ROWS;

   typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FINISH} state_t;

   state_t        state;
   logic [W-1:0]  fb [H];
   logic [YW-1:0] clr_row;
   logic [3:0]    row_idx;
   logic [3:0]    n_rows;
   logic [XW-1:0] x0;
   logic [YW-1:0] y0;
   logic [SW-1:0] spr;       // row under draw is always the top byte
   logic          coll;
   logic          is_draw;   // FINISH reached from a draw (vs. a clear)
   logic          done_q;
   logic [7:0]    vf_q;

   logic [7:0]    cur_byte;
   logic [7:0]    rev_byte;
   logic [W-1:0]  mask;
   logic [W-1:0]  old_row;
   logic [YW+3:0] tgt_y;
   logic          tgt_ok;

   // NOTE: every signal is assigned unconditionally at the top of this
   // block, so no path can leave one unassigned and infer a latch.
   always_comb begin
      cur_byte = spr[SW-1 -: 8];
      // Bit 7 is the leftmost pixel, so reverse it to land on column x0.
      rev_byte = {<<{cur_byte}};
      // Bits shifted past column W-1 fall off: horizontal clipping.
      mask     = W'({{W{1'b0}}, rev_byte} << x0);
      tgt_y    = {4'b0, y0} + {{YW{1'b0}}, row_idx};
      // H is a power of two, so any bit above the row field means clipped.
      tgt_ok   = (tgt_y[YW+3:YW] == 4'b0);
      old_row  = fb[tgt_y[YW-1:0]];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         // NOTE: the framebuffer is built from flops, not a RAM macro, so
         // it can and does take the asynchronous reset like any register.
         for (int r = 0; r < H; r++) fb[r] <= '0;
         clr_row <= '0;
         row_idx <= '0;
         n_rows  <= '0;
         x0      <= '0;
         y0      <= '0;
         spr     <= '0;
         coll    <= 1'b0;
         is_draw <= 1'b0;
         done_q  <= 1'b0;
         vf_q    <= 8'h00;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd.gpu_clear) begin
                  clr_row <= '0;
                  is_draw <= 1'b0;
                  state   <= CLEAR;
               end else if (cmd.gpu_draw) begin
                  x0      <= XW'(cmd.vx % W);
                  y0      <= YW'(cmd.vy % H);
                  n_rows  <= cmd.n_bits;
                  spr     <= cmd.sprite_data;
                  row_idx <= '0;
                  coll    <= 1'b0;
                  is_draw <= 1'b1;
                  if (cmd.n_bits == 4'd0) begin
                     state  <= FINISH;
                     done_q <= 1'b1;
                  end else begin
                     state  <= DRAW;
                  end
               end
            end
            CLEAR: begin
               fb[clr_row] <= '0;
               if (clr_row == YW'(H - 1)) begin
                  state  <= FINISH;
                  done_q <= 1'b1;
               end else begin
                  clr_row <= clr_row + 1'b1;
               end
            end
            DRAW: begin
               if (tgt_ok) begin
                  fb[tgt_y[YW-1:0]] <= old_row ^ mask;
                  coll              <= coll | (|(old_row & mask));
               end
               spr     <= spr << 8;
               row_idx <= row_idx + 1'b1;
               if (row_idx == n_rows - 4'd1) begin
                  state  <= FINISH;
                  done_q <= 1'b1;
               end
            end
            FINISH: begin
               if (is_draw) vf_q <= {7'b0, coll};
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd.busy = (state != IDLE);
   assign cmd.done = done_q;
   assign cmd.vf   = vf_q;
   assign pix_out  = fb[pix_y][pix_x];

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
Responder side of the CPU's display command interface. Accepts gpu_clear / gpu_draw requests with coordinates and sprite bytes, XOR-draws sprites into an internal 64x32 1-bpp framebuffer, and returns the collision flag the CPU loads into VF. Provides a combinational pixel read port for the video scan-out logic.

Parameters:
W, 64, framebuffer width in pixels (power of two)
H, 32, framebuffer height in pixels (power of two)
MAX_ROWS, 15, maximum sprite height; sprite_data width is 8*MAX_ROWS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
gpu_clear  input  1  clear-screen request, sampled on the clk edge
gpu_draw  input  1  draw-sprite request, sampled on the clk edge
vx  input  8  sprite X origin
vy  input  8  sprite Y origin
n_bits  input  4  sprite height in rows (0..15)
sprite_data  input  8*MAX_ROWS  sprite bytes; row i = sprite_data[8*MAX_ROWS-1-8*i -: 8], bit 7 = leftmost pixel
busy  output  1  command in progress; new requests ignored
done  output  1  one-cycle completion pulse
vf  output  8  collision result: 8'h01 if any lit pixel was turned off by the last draw, else 8'h00
pix_x  input  6  read-port column (log2 W bits)
pix_y  input  5  read-port row (log2 H bits)
pix_out  output  1  framebuffer bit at (pix_x, pix_y), combinational

Behaviour:
- Reset (async, rst_n low): state IDLE, busy=0, done=0, vf=8'h00, entire framebuffer cleared to 0. Reset mid-command aborts it with no done pulse.
- Storage: H rows of W bits in registers; row-wide read-modify-write, one row per cycle.
- FSM states: IDLE, CLEAR, DRAW, FINISH.
- IDLE: on an edge with gpu_clear=1 -> CLEAR, row counter=0. Otherwise, on gpu_draw=1 -> latch x0=vx mod W, y0=vy mod H, n=n_bits, sprite_data; clear the collision accumulator; -> DRAW with row index i=0 (-> FINISH directly if n=0). Both high on the same edge: clear wins, draw dropped.
- Requests are accepted only in IDLE; pulses arriving while busy=1 are dropped (no queueing). Requests are level-sampled: a request held high for several cycles in IDLE is accepted once per return to IDLE.
- busy=1 in CLEAR, DRAW, FINISH; combinational from state.
- CLEAR: zero one row per cycle, rows 0..H-1 (H cycles), then -> FINISH. vf is unchanged by a clear.
- DRAW: each cycle processes sprite row i, target row y0+i.
  - If y0+i >= H, the row is clipped (no write, no collision contribution); no vertical wrap.
  - Horizontal: sprite bit b (7=left) maps to column x0+(7-b); columns >= W are clipped; no horizontal wrap.
  - new_row = old_row XOR mask; collision |= |(old_row AND mask).
  - i increments; after row n-1 -> FINISH.
- FINISH: done=1 for exactly this cycle. A draw updates vf to {7'b0, collision} on the edge leaving FINISH, so vf is valid in the cycle after done and holds until the next completed draw. Next state IDLE.
- Latency from the accept edge to done high: draw = n+1 edges (n=0: 1 edge); clear = H+1 edges.
- pix_out reflects the current register contents at all times, including mid-command (partially drawn rows are visible).
- Inputs vx/vy/n_bits/sprite_data may change after the accept edge without affecting the command in progress.

Test Plan:
- Reset then read all 2048 pixels -> all 0; busy=0, done=0, vf=8'h00.
- Draw vx=0, vy=0, n=5, rows F0,90,90,90,F0 ("0" glyph) -> done exactly 6 edges after accept; pix(0..3,0)=1, pix(1,1)=0, pix(0,1)=1; vf=8'h00.
- Repeat the same draw -> all pixels back to 0, vf=8'h01.
- Draw vx=62, vy=30, n=3, rows FF,FF,FF -> only (62,30),(63,30),(62,31),(63,31) set; row 0 and column 0 untouched (clipping); vf=8'h00.
- vx=200, vy=40, n=1, row 80 -> pixel (8,8) set (coordinates mod W/H); n=0 draw -> done 1 edge after accept, vf=8'h00.
- Assert gpu_draw during CLEAR and gpu_clear+gpu_draw together in IDLE -> dropped draw has no effect, clear takes H+1 edges to done; rst_n low mid-DRAW -> busy=0 and framebuffer all 0 immediately, no done pulse.
